// File: rtl/mio_pkg.sv
// ----------------------------------------------------------------------------
// mio_pkg
// Shared definitions for the memory/I-O bus bridge.
//   state_e       : bridge FSM state encoding
//   IO_BASE       : cpu_addr[31:28] value that selects the I/O space
//   OFF_LED/SW/CNT: byte offsets of the I/O registers, with address bits [1:0] cleared
// ----------------------------------------------------------------------------
package mio_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RAM_WAIT = 2'd1,
        RESP     = 2'd2
    } state_e;

    localparam logic [3:0]  IO_BASE = 4'hF;

    localparam logic [27:0] OFF_LED = 28'h000_0000;
    localparam logic [27:0] OFF_SW  = 28'h000_0004;
    localparam logic [27:0] OFF_CNT = 28'h000_0008;

    // True when a CPU byte address falls into the I/O space.
    function automatic logic is_io(input logic [3:0] addr_top);
        return addr_top == IO_BASE;
    endfunction

endpackage

// File: rtl/mio_io_regs.sv
// ----------------------------------------------------------------------------
// mio_io_regs
// Memory-mapped I/O register block: LED register, free-running counter and the
// switch read mux.
//   clk, reset : clock, asynchronous active-low reset
//   wr_en      : one-cycle write strobe for the addressed register
//   offset     : byte offset within the I/O space, with bits [1:0] already cleared
//   wdata      : write data
//   sw_in      : switch inputs
//   rdata      : combinational read data for the addressed register (0 if unmapped)
//   led_out    : LED register contents
// ----------------------------------------------------------------------------
module mio_io_regs
    import mio_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        wr_en,
    input  logic [27:0] offset,
    input  logic [31:0] wdata,
    input  logic [15:0] sw_in,
    output logic [31:0] rdata,
    output logic [15:0] led_out
);

    logic [15:0] led_q;
    logic [31:0] counter_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            led_q     <= '0;
            counter_q <= '0;
        end else begin
            if (wr_en && (offset == OFF_LED)) begin
                led_q <= wdata[15:0];
            end
            // A CPU load wins over the free-running increment; wrap is natural.
            if (wr_en && (offset == OFF_CNT)) begin
                counter_q <= wdata;
            end else begin
                counter_q <= counter_q + 32'd1;
            end
        end
    end

    always_comb begin
        rdata = '0;
        case (offset)
            OFF_LED: rdata = {16'h0000, led_q};
            OFF_SW:  rdata = {16'h0000, sw_in};
            OFF_CNT: rdata = counter_q;
            default: rdata = '0;
        endcase
    end

    assign led_out = led_q;

endmodule

// File: rtl/mio_bus.sv
// ----------------------------------------------------------------------------
// mio_bus
// Bridges a single-outstanding CPU request port onto a fixed-latency
// synchronous RAM and a small I/O register block.
//   clk, reset            : clock, asynchronous active-low reset
//   cpu_req/we/addr/wdata : CPU request, held until cpu_ready
//   cpu_rdata, cpu_ready  : one-cycle completion pulse with read data (0 on writes)
//   ram_en/we/addr/wdata  : RAM command, ram_en is a single-cycle strobe
//   ram_rdata             : RAM read data, valid RAM_LAT cycles after the ram_en cycle
//   led_out, sw_in        : LED register output, switch inputs
// Latency from acceptance to cpu_ready: RAM_LAT+2 cycles for RAM, 1 for I/O.
// ----------------------------------------------------------------------------
module mio_bus
    import mio_pkg::*;
#(
    parameter int unsigned RAM_LAT = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        cpu_ready,
    output logic        ram_en,
    output logic        ram_we,
    output logic [9:0]  ram_addr,
    output logic [31:0] ram_wdata,
    input  logic [31:0] ram_rdata,
    output logic [15:0] led_out,
    input  logic [15:0] sw_in
);

    localparam logic [2:0] LAT_CNT = 3'(RAM_LAT);

    state_e      state;
    logic [2:0]  wait_cnt;
    logic        req_io;
    logic        io_wr;
    logic [27:0] io_offset;
    logic [31:0] io_rdata;

    // Byte-lane bits are not decoded by either target.
    logic unused_addr_bits;
    assign unused_addr_bits = ^cpu_addr[1:0];

    assign req_io    = is_io(cpu_addr[31:28]);
    assign io_offset = {cpu_addr[27:2], 2'b00};
    assign io_wr     = (state == IDLE) && cpu_req && req_io && cpu_we;

    mio_io_regs u_io_regs (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (io_wr),
        .offset  (io_offset),
        .wdata   (cpu_wdata),
        .sw_in   (sw_in),
        .rdata   (io_rdata),
        .led_out (led_out)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            wait_cnt  <= '0;
            cpu_ready <= 1'b0;
            cpu_rdata <= '0;
            ram_en    <= 1'b0;
            ram_we    <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= '0;
        end else begin
            ram_en    <= 1'b0;
            cpu_ready <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (cpu_req) begin
                        if (req_io) begin
                            // I/O completes immediately; the write (if any) lands this edge.
                            cpu_rdata <= cpu_we ? 32'h0 : io_rdata;
                            cpu_ready <= 1'b1;
                            state     <= RESP;
                        end else begin
                            ram_en    <= 1'b1;
                            ram_we    <= cpu_we;
                            ram_addr  <= cpu_addr[11:2];
                            ram_wdata <= cpu_wdata;
                            wait_cnt  <= '0;
                            state     <= RAM_WAIT;
                        end
                    end
                end
                RAM_WAIT: begin
                    // wait_cnt is 0 during the ram_en cycle and reaches RAM_LAT on the
                    // cycle in which ram_rdata is valid.
                    if (wait_cnt == LAT_CNT) begin
                        cpu_rdata <= ram_we ? 32'h0 : ram_rdata;
                        cpu_ready <= 1'b1;
                        wait_cnt  <= '0;
                        state     <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt + 3'd1;
                    end
                end
                RESP: begin
                    cpu_rdata <= '0;
                    state     <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mio_bus.sv
// ----------------------------------------------------------------------------
// tb_mio_bus
// Directed bench for mio_bus with a transaction-level reference model that is
// compared against the DUT on every falling clock edge, plus literal checks.
// ----------------------------------------------------------------------------
module tb_mio_bus;

    localparam int unsigned LAT = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        cpu_req = 1'b0;
    logic        cpu_we = 1'b0;
    logic [31:0] cpu_addr = '0;
    logic [31:0] cpu_wdata = '0;
    logic [31:0] cpu_rdata;
    logic        cpu_ready;
    logic        ram_en;
    logic        ram_we;
    logic [9:0]  ram_addr;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;
    logic [15:0] led_out;
    logic [15:0] sw_in = '0;

    mio_bus #(.RAM_LAT(LAT)) dut (
        .clk       (clk),
        .reset     (reset),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .cpu_ready (cpu_ready),
        .ram_en    (ram_en),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata),
        .led_out   (led_out),
        .sw_in     (sw_in)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // RAM device: read data is driven only in the single cycle it is valid.
    logic [31:0] dev_mem [0:1023];
    logic [31:0] dev_data;
    int          dev_cnt;
    always @(posedge clk) begin
        if (!reset) begin
            dev_cnt <= 0;
        end else begin
            if (dev_cnt > 0) dev_cnt <= dev_cnt - 1;
            if (ram_en) begin
                if (ram_we) begin
                    dev_mem[ram_addr] <= ram_wdata;
                end else begin
                    dev_data <= dev_mem[ram_addr];
                    dev_cnt  <= int'(LAT);
                end
            end
        end
    end
    assign ram_rdata = (dev_cnt == 1) ? dev_data : 32'hBAD0_BAD0;

    int n_cmp = 0;
    int n_fail = 0;

    function automatic void check(input string name, input logic [31:0] got,
                                  input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h (cycle %0d)", name, got, exp, cyc);
        end
    endfunction

    // Reference model state (transaction level).
    logic [31:0] m_mem [0:1023];
    int          m_busy_end;
    int          m_ready_cyc;
    logic [31:0] m_rdata;
    int          m_en_cyc;
    logic        m_en_we;
    logic [9:0]  m_en_addr;
    logic [31:0] m_en_wdata;
    logic [15:0] m_led;
    logic [31:0] m_cnt_base;
    int          m_cnt_cyc;

    // Observed statistics used by the directed checks.
    int          ready_cnt = 0;
    int          en_cnt = 0;
    int          en_prev = -1;
    int          en_gap = 0;
    logic [9:0]  en_addr_last = '0;

    task automatic compare_cycle();
        logic [31:0] exp_rd;
        logic [27:0] off;
        int          lat;
        if (!reset) begin
            m_busy_end  = -1;
            m_ready_cyc = -1;
            m_en_cyc    = -1;
            m_led       = '0;
            m_cnt_base  = '0;
            m_cnt_cyc   = cyc + 1;
            en_prev     = -1;
            check("rst_cpu_ready", 32'(cpu_ready), 32'd0);
            check("rst_cpu_rdata", cpu_rdata, 32'd0);
            check("rst_ram_en", 32'(ram_en), 32'd0);
            check("rst_ram_we", 32'(ram_we), 32'd0);
            check("rst_ram_addr", 32'(ram_addr), 32'd0);
            check("rst_ram_wdata", ram_wdata, 32'd0);
            check("rst_led_out", 32'(led_out), 32'd0);
            return;
        end
        check("cpu_ready", 32'(cpu_ready), 32'(cyc == m_ready_cyc));
        if (cpu_ready) ready_cnt++;
        if (cyc == m_ready_cyc) check("cpu_rdata", cpu_rdata, m_rdata);
        check("ram_en", 32'(ram_en), 32'(cyc == m_en_cyc));
        if (cyc == m_en_cyc) begin
            check("ram_we", 32'(ram_we), 32'(m_en_we));
            check("ram_addr", 32'(ram_addr), 32'(m_en_addr));
            if (m_en_we) check("ram_wdata", ram_wdata, m_en_wdata);
        end
        if (ram_en) begin
            if (en_prev >= 0) en_gap = cyc - en_prev;
            en_prev      = cyc;
            en_cnt++;
            en_addr_last = ram_addr;
        end
        check("led_out", 32'(led_out), 32'(m_led));

        if (cpu_req && (cyc > m_busy_end)) begin
            exp_rd = '0;
            if (cpu_addr[31:28] == 4'hF) begin
                lat = 1;
                off = {cpu_addr[27:2], 2'b00};
                if (cpu_we) begin
                    if (off == 28'h0) begin
                        m_led = cpu_wdata[15:0];
                    end else if (off == 28'h8) begin
                        m_cnt_base = cpu_wdata;
                        m_cnt_cyc  = cyc + 1;
                    end
                end else begin
                    if (off == 28'h0)      exp_rd = {16'h0000, m_led};
                    else if (off == 28'h4) exp_rd = {16'h0000, sw_in};
                    else if (off == 28'h8) exp_rd = m_cnt_base + 32'(cyc - m_cnt_cyc);
                end
            end else begin
                lat        = int'(LAT) + 2;
                m_en_cyc   = cyc + 1;
                m_en_we    = cpu_we;
                m_en_addr  = cpu_addr[11:2];
                m_en_wdata = cpu_wdata;
                if (cpu_we) m_mem[cpu_addr[11:2]] = cpu_wdata;
                else        exp_rd = m_mem[cpu_addr[11:2]];
            end
            m_ready_cyc = cyc + lat;
            m_busy_end  = m_ready_cyc;
            m_rdata     = exp_rd;
        end
    endtask

    task automatic wait_ready(input string name, output logic [31:0] rdata, output int at);
        bit seen;
        seen  = 1'b0;
        rdata = '0;
        at    = -1;
        for (int i = 0; i < 30 && !seen; i++) begin
            @(negedge clk);
            if (cpu_ready) begin
                seen  = 1'b1;
                rdata = cpu_rdata;
                at    = cyc;
            end
        end
        if (!seen) begin
            n_cmp++;
            n_fail++;
            $display("FAIL %s_timeout: no cpu_ready within 30 cycles, required one", name);
        end
    endtask

    task automatic do_txn(input string name, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, output logic [31:0] rdata,
                          output int lat);
        int start;
        int at;
        cpu_req   = 1'b1;
        cpu_we    = we;
        cpu_addr  = addr;
        cpu_wdata = wdata;
        start     = cyc;
        wait_ready(name, rdata, at);
        lat = (at < 0) ? -1 : at - start;
        @(posedge clk); #1;
        cpu_req = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    logic [31:0] rd;
    logic [31:0] rd2;
    int          lat;
    int          at;
    int          at2;
    int          en0;
    int          r0;

    initial begin
        fork
            forever begin
                @(negedge clk);
                compare_cycle();
            end
        join_none

        idle(3);
        reset = 1'b1;

        // Counter read straight out of reset, checked by the model.
        do_txn("cnt_rd0", 1'b0, 32'hF000_0008, 32'h0, rd, lat);

        // RAM write then read, word address 4.
        en0 = en_cnt;
        do_txn("ram_wr", 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, rd, lat);
        check("ram_wr_lat", 32'(lat), 32'd4);
        check("ram_wr_en_pulses", 32'(en_cnt - en0), 32'd1);
        check("ram_wr_addr", 32'(en_addr_last), 32'd4);
        check("ram_wr_rdata", rd, 32'h0);
        en0 = en_cnt;
        do_txn("ram_rd", 1'b0, 32'h0000_0010, 32'h0, rd, lat);
        check("ram_rd_lat", 32'(lat), 32'd4);
        check("ram_rd_en_pulses", 32'(en_cnt - en0), 32'd1);
        check("ram_rd_addr", 32'(en_addr_last), 32'd4);
        check("ram_rd_data", rd, 32'hDEAD_BEEF);
        // Upper non-I/O bits and byte lane are ignored.
        do_txn("ram_alias", 1'b0, 32'hE000_1013, 32'h0, rd, lat);
        check("ram_alias_data", rd, 32'hDEAD_BEEF);

        // LED register.
        do_txn("led_wr", 1'b1, 32'hF000_0000, 32'h1234_ABCD, rd, lat);
        check("led_wr_lat", 32'(lat), 32'd1);
        check("led_value", 32'(led_out), 32'h0000_ABCD);
        do_txn("led_rd", 1'b0, 32'hF000_0000, 32'h0, rd, lat);
        check("led_rd_lat", 32'(lat), 32'd1);
        check("led_rd_data", rd, 32'h0000_ABCD);

        // Switches are read-only.
        sw_in = 16'h00FF;
        do_txn("sw_rd", 1'b0, 32'hF000_0004, 32'h0, rd, lat);
        check("sw_rd_data", rd, 32'h0000_00FF);
        do_txn("sw_wr", 1'b1, 32'hF000_0004, 32'h1234_5678, rd, lat);
        check("sw_wr_lat", 32'(lat), 32'd1);
        do_txn("sw_rd2", 1'b0, 32'hF000_0004, 32'h0, rd, lat);
        check("sw_rd2_data", rd, 32'h0000_00FF);

        // Counter wrap: load 0xFFFFFFFE, read three cycles after acceptance.
        do_txn("cnt_wr", 1'b1, 32'hF000_0008, 32'hFFFF_FFFE, rd, lat);
        idle(1);
        do_txn("cnt_rd", 1'b0, 32'hF000_0008, 32'h0, rd, lat);
        check("cnt_wrap", rd, 32'h0000_0000);

        // Unmapped write completes and changes nothing.
        do_txn("unmap_wr", 1'b1, 32'hF000_000C, 32'hFFFF_FFFF, rd, lat);
        check("unmap_wr_lat", 32'(lat), 32'd1);

        // Back-to-back RAM reads with cpu_req held high.
        do_txn("ram_wr2", 1'b1, 32'h0000_0020, 32'hCAFE_F00D, rd, lat);
        en0       = en_cnt;
        cpu_req   = 1'b1;
        cpu_we    = 1'b0;
        cpu_addr  = 32'h0000_0010;
        wait_ready("b2b_first", rd, at);
        @(posedge clk); #1;
        cpu_addr = 32'h0000_0020;
        wait_ready("b2b_second", rd2, at2);
        @(posedge clk); #1;
        cpu_req = 1'b0;
        check("b2b_first_data", rd, 32'hDEAD_BEEF);
        check("b2b_second_data", rd2, 32'hCAFE_F00D);
        check("b2b_en_pulses", 32'(en_cnt - en0), 32'd2);
        check("b2b_en_gap_ok", 32'(en_gap >= int'(LAT) + 2), 32'd1);
        check("b2b_ready_spacing", 32'(at2 - at), 32'd5);

        // Reset during RAM_WAIT aborts the read.
        cpu_req  = 1'b1;
        cpu_we   = 1'b0;
        cpu_addr = 32'h0000_0020;
        idle(2);
        reset   = 1'b0;
        cpu_req = 1'b0;
        r0      = ready_cnt;
        idle(4);
        check("rst_no_ready", 32'(ready_cnt - r0), 32'd0);
        reset = 1'b1;
        do_txn("post_rst_rd", 1'b0, 32'hF000_000C, 32'h0, rd, lat);
        check("post_rst_rd_lat", 32'(lat), 32'd1);
        check("post_rst_rd_data", rd, 32'h0);
        check("post_rst_led", 32'(led_out), 32'h0);

        idle(3);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/mio_bus.md
MIO_BUS -- requirements
Module: mio_bus

Interface
REQ-001 The module SHALL have parameter RAM_LAT, default 2, giving RAM read/write latency in cycles (legal range 1-7).
REQ-002 The module SHALL have port clk, input, 1 bit: the single clock, rising-edge.
REQ-003 The module SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-004 The module SHALL have port cpu_req, input, 1 bit: CPU memory request, held high until cpu_ready.
REQ-005 The module SHALL have port cpu_we, input, 1 bit: 1 = write, 0 = read.
REQ-006 The module SHALL have port cpu_addr, input, 32 bits: byte address.
REQ-007 The module SHALL have port cpu_wdata, input, 32 bits: write data.
REQ-008 The module SHALL have port cpu_rdata, output, 32 bits: read data, valid while cpu_ready=1.
REQ-009 The module SHALL have port cpu_ready, output, 1 bit: one-cycle completion pulse.
REQ-010 The module SHALL have the RAM-side ports: ram_en (out, 1), ram_we (out, 1), ram_addr (out, 10, word address), ram_wdata (out, 32), ram_rdata (in, 32).
REQ-011 The module SHALL have the I/O ports: led_out (out, 16) and sw_in (in, 16).

Function
REQ-012 Address decode SHALL be: cpu_addr[31:28]==4'hF selects I/O; any other value selects RAM with ram_addr = cpu_addr[11:2]; cpu_addr[1:0] ignored.
REQ-013 The I/O map SHALL be: offset 0x0 LED register (R/W, low 16 bits); 0x4 switches (read-only, zero-extended sw_in); 0x8 counter (R/W, 32 bits).
REQ-014 Unmapped I/O offsets SHALL read 0, ignore writes, and still complete with cpu_ready.
REQ-015 The FSM states SHALL be IDLE, RAM_WAIT, RESP.
REQ-016 In IDLE, cpu_req=1 to RAM SHALL drive ram_en=1 for exactly one cycle, with ram_we=cpu_we, ram_addr, and ram_wdata registered from the request, then enter RAM_WAIT.
REQ-017 RAM_WAIT SHALL count RAM_LAT cycles after the ram_en cycle, capture ram_rdata on the last count, then enter RESP.
REQ-018 In IDLE, cpu_req=1 to I/O SHALL perform the register write or read capture in that cycle and enter RESP.
REQ-019 RESP SHALL assert cpu_ready=1 for exactly one cycle with captured cpu_rdata (0 for writes), then return to IDLE.
REQ-020 Requests SHALL be accepted only in IDLE; cpu_req changes outside IDLE are ignored; the next request is sampled no earlier than the cycle after RESP.
REQ-021 Latency from request acceptance to cpu_ready SHALL be RAM_LAT+2 cycles for RAM and 1 cycle for I/O.
REQ-022 The counter SHALL increment every cycle, wrapping 0xFFFFFFFF->0; a CPU write loads cpu_wdata and takes precedence over the increment in that cycle.
REQ-023 A counter read SHALL return the value present in the capture cycle.
REQ-024 ram_en SHALL be 0 in all cycles except the REQ-016 cycle.

Reset
REQ-025 While reset=0, the module SHALL force: state IDLE, cpu_ready 0, cpu_rdata 0, ram_en 0, ram_we 0, ram_addr 0, ram_wdata 0, led_out 0, counter 0, wait count 0.
REQ-026 Reset asserted mid-transaction SHALL abort it with no cpu_ready pulse; on release the module SHALL be in IDLE and accept a request on the first clock edge.

Structure
REQ-027 A shared package mio_pkg SHALL hold the FSM state encoding, the I/O base (4'hF), and the offset constants 0x0/0x4/0x8.
REQ-028 The I/O registers (LED, counter, switch read mux) SHALL be one sub-module, mio_io_regs; the FSM and RAM sequencing SHALL stay in mio_bus.

Verification
REQ-029 The bench SHALL cover: RAM write 0x0000_0010 <= 0xDEADBEEF, then read with RAM_LAT=2 -> ram_addr=4, one ram_en pulse each, cpu_ready 4 cycles after acceptance, cpu_rdata=0xDEADBEEF.
REQ-030 The bench SHALL cover: write 0x1234ABCD to 0xF000_0000 -> led_out=0xABCD; read -> 0x0000ABCD, cpu_ready 1 cycle after acceptance.
REQ-031 The bench SHALL cover: sw_in=0x00FF, read 0xF000_0004 -> 0x000000FF; write to it -> sw unchanged, cpu_ready still pulses.
REQ-032 The bench SHALL cover: write 0xFFFFFFFE to counter, read 3 cycles later -> wrapped value 0x00000000 or later, consistent with REQ-022/023.
REQ-033 The bench SHALL cover: reset=0 during RAM_WAIT -> no cpu_ready; after release, an I/O read of 0xF000_000C returns 0 and led_out=0.
REQ-034 The bench SHALL cover: cpu_req held high across back-to-back RAM reads -> exactly one ram_en per transaction, separated by at least RAM_LAT+2 cycles.
